// File: rtl/if_prefetch_stage_if.sv
// Handshake bundles for the IF prefetch stage:
// instruction SRAM request/response and the IF->OF valid/ready link.
interface imem_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;

  modport master (output imem_en, imem_addr, input imem_data);
  modport slave  (input imem_en, imem_addr, output imem_data);
endinterface

interface if_of_if #(
  parameter int XLEN = 32,
  parameter int DW   = 32
);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [DW-1:0]   instr;

  modport master (output valid, pc, instr, input ready);
  modport slave  (input valid, pc, instr, output ready);
endinterface

// File: rtl/if_prefetch_stage.sv
// IF stage: PC generation, sync imem fetch, {pc,instr} prefetch queue.
// Optional IF_PERF_CNT_EN builds fetch/flush performance counters.
module if_prefetch_stage #(
  parameter int XLEN            = 32,
  parameter int INST_ADDR_WIDTH = 12,
  parameter int INST_DATA_WIDTH = 32,
  parameter int FQ_DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_ex_branch_taken,
  input  logic [XLEN-1:0] i_ex_branch_pc,
  imem_if.master io_imem,
  if_of_if.master io_of,
  output logic [$clog2(FQ_DEPTH):0] o_fq_count,
  output logic [31:0] o_perf_fetch_cnt,
  output logic [31:0] o_perf_flush_cnt
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = INST_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_REDIR
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;

  logic [XLEN-1:0] r_q_pc    [FQ_DEPTH];
  logic [DW-1:0]   r_q_instr [FQ_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic          w_redirect;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_used;
  logic          w_unused_pc;

  // Redirects outside IDLE flush; in IDLE they only retarget the PC.
  assign w_redirect = i_ex_branch_taken & (r_state != S_IDLE);

  assign w_used = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_issue = (r_state == S_RUN) & ~i_ex_branch_taken
                 & (w_used < (CW+1)'(FQ_DEPTH));

  assign w_push = r_inflight & ~w_redirect;
  assign w_pop  = io_of.valid & io_of.ready & ~w_redirect;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (r_state)
      S_IDLE: begin
        if (i_ex_branch_taken) begin
          w_pc_nxt = i_ex_branch_pc;
        end else if (i_start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (i_ex_branch_taken) begin
          w_state_nxt = S_REDIR;
          w_pc_nxt    = i_ex_branch_pc;
        end else if (w_issue) begin
          w_pc_nxt = r_pc + XLEN'(4);
        end
      end
      S_REDIR: begin
        if (i_ex_branch_taken) begin
          w_pc_nxt = i_ex_branch_pc;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else if (w_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q_pc[r_wr_ptr]    <= r_inflight_pc;
        r_q_instr[r_wr_ptr] <= io_imem.imem_data;
        r_wr_ptr            <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign io_imem.imem_en   = w_issue;
  assign io_imem.imem_addr = w_issue ? r_pc[INST_ADDR_WIDTH+1:2] : '0;

  assign io_of.valid = (r_count != '0);
  assign io_of.pc    = r_q_pc[r_rd_ptr];
  assign io_of.instr = r_q_instr[r_rd_ptr];
  assign o_fq_count  = r_count;

  assign w_unused_pc = ^{r_pc[1:0], r_pc[XLEN-1:INST_ADDR_WIDTH+2]};

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_issue) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (w_redirect) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign o_perf_fetch_cnt = r_perf_fetch;
  assign o_perf_flush_cnt = r_perf_flush;
`else
  assign o_perf_fetch_cnt = '0;
  assign o_perf_flush_cnt = '0;
`endif

endmodule
